// File: rtl/chicken_pkg.sv
// Shared configuration and state encodings for the chicken game datapath.
package chicken_pkg;
  localparam int NTILES = 12;
  localparam int LAPS = 1;
  localparam logic [3:0] NO_KEY = 4'hf;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHUF  = 3'd1,
    READY = 3'd2,
    LOOK  = 3'd3,
    JUDGE = 3'd4,
    OVER  = 3'd5
  } state_t;
endpackage

// File: rtl/chicken_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); low byte feeds the shuffler.
module chicken_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rnd
);
  logic [15:0] state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEED;
    else      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
  end

  assign rnd = state[7:0];
endmodule

// File: rtl/chicken_judge.sv
// Game responder: shuffles the board, reveals requested cards, judges them against the
// tile ahead of the chicken and tracks position, laps and the win condition.
module chicken_judge
  import chicken_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req,
  input  logic [3:0]        card_sel,
  output logic              ready,
  output logic              ack,
  output logic              go,
  output logic              win,
  output logic              err,
  output logic [3:0]        pic,
  output logic [3:0]        pos,
  output logic [NTILES-1:0] flipped
);
  localparam logic [3:0] NT4   = 4'(NTILES);
  localparam logic [3:0] LAST  = 4'(NTILES - 1);
  localparam logic [2:0] LAPS3 = 3'(LAPS);

  state_t     state;
  logic [3:0] sel;
  logic [3:0] i;
  logic [3:0] j;
  logic [3:0] nxt;
  logic [2:0] lap;
  logic [7:0] rnd;
  logic [3:0] tile [NTILES];
  logic       sel_ok;
  logic       match;

  chicken_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  assign nxt    = (pos == LAST) ? 4'd0 : pos + 4'd1;
  assign j      = 4'(rnd % ({4'd0, i} + 8'd1));
  assign sel_ok = (sel < NT4) && !flipped[sel];
  assign match  = (pic == tile[nxt]);

  // Board contents are pure data: reloaded on every start, never reset.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int t = 0; t < NTILES; t++) tile[t] <= 4'(t);
    end else if (state == SHUF) begin
      tile[i] <= tile[j];
      tile[j] <= tile[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready   <= 1'b0;
      ack     <= 1'b0;
      go      <= 1'b0;
      win     <= 1'b0;
      err     <= 1'b0;
      pic     <= 4'd0;
      pos     <= 4'd0;
      flipped <= '0;
      lap     <= 3'd0;
      sel     <= NO_KEY;
      i       <= 4'd0;
    end else begin
      ack <= 1'b0;
      if (start) begin
        state <= SHUF;
        ready <= 1'b0;
        win   <= 1'b0;
        i     <= LAST;
      end else begin
        case (state)
          IDLE, OVER: ;
          SHUF: begin
            i <= i - 4'd1;
            if (i <= 4'd1) begin
              state   <= READY;
              ready   <= 1'b1;
              pos     <= 4'd0;
              lap     <= 3'd0;
              flipped <= '0;
            end
          end
          READY: begin
            if (req) begin
              sel   <= card_sel;
              ready <= 1'b0;
              state <= LOOK;
            end
          end
          LOOK: begin
            if (!sel_ok) begin
              err   <= 1'b1;
              ack   <= 1'b1;
              go    <= 1'b0;
              ready <= 1'b1;
              state <= READY;
            end else begin
              pic          <= sel;
              flipped[sel] <= 1'b1;
              state        <= JUDGE;
            end
          end
          JUDGE: begin
            ack <= 1'b1;
            err <= 1'b0;
            if (match) begin
              go  <= 1'b1;
              pos <= nxt;
              if (nxt == 4'd0) lap <= lap + 3'd1;
              // A lap completes when the chicken wraps back onto tile 0.
              if (nxt == 4'd0 && (lap + 3'd1) >= LAPS3) begin
                win   <= 1'b1;
                state <= OVER;
              end else begin
                ready <= 1'b1;
                state <= READY;
              end
            end else begin
              go      <= 1'b0;
              flipped <= '0;
              ready   <= 1'b1;
              state   <= READY;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
